// File: rtl/core_pkg.sv
// Shared definitions for the 9-bit single-cycle core.
// Holds the run-controller state enum, the halt instruction encoding,
// the PC width and a halt-decode helper.
package core_pkg;

  localparam int PC_W = 16;

  localparam logic [3:0] OPC_HALT = 4'b1011;
  localparam logic       FMT_HALT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // True when the decoded format/opcode pair is the halt instruction.
  function automatic logic is_halt(input logic fmt, input logic [3:0] opc);
    return (fmt == FMT_HALT) && (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer and run controller.
// Drives the PC into the combinational instruction ROM, applies branch
// redirects and stalls, detects halt, runs the start/done handshake,
// counts retired instructions (saturating) and flags runaway programs.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               level request to run from START_PC
//   format, opcode      decoded instruction fields from the ROM
//   branch_taken/target redirect request and address
//   stall               hold the current instruction this cycle
//   pc_out              registered PC to the ROM
//   run                 current instruction retires this cycle
//   done, fault         registered status flags (halted / runaway)
//   instr_count         retired-instruction count, saturating
module fetch_sequencer
  import core_pkg::*;
#(
  parameter logic [PC_W-1:0] START_PC = 16'd0,
  parameter logic [PC_W-1:0] PROG_LEN = 16'd132
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            format,
  input  logic [3:0]      opcode,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            stall,
  output logic [PC_W-1:0] pc_out,
  output logic            run,
  output logic            done,
  output logic            fault,
  output logic [PC_W-1:0] instr_count
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   pc_nxt_s;
  logic [PC_W-1:0]   cnt_r;
  logic [PC_W-1:0]   cnt_nxt_s;
  logic [PC_W-1:0]   cnt_inc_s;
  logic [PC_W-1:0]   seq_pc_s;
  logic              halt_s;
  logic              in_run_r;
  logic              done_r;
  logic              fault_r;

  // Decode, sequential next PC (wraps naturally at 16 bits) and saturating count.
  always_comb begin
    halt_s    = is_halt(format, opcode);
    seq_pc_s  = branch_taken ? branch_target : (pc_r + 16'd1);
    cnt_inc_s = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
  end

  // Next-state, next-PC and next-count selection.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        pc_nxt_s = START_PC;
        if (start) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stall) begin
          state_nxt_s = ST_RUN;
        end else if (halt_s) begin
          // Halt wins over a simultaneous branch; PC stays on the halt.
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = cnt_inc_s;
        end else begin
          pc_nxt_s  = seq_pc_s;
          cnt_nxt_s = cnt_inc_s;
          // Range check applies to the updated PC, on the same edge.
          if (seq_pc_s >= PROG_LEN) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_DONE, ST_FAULT: begin
        if (!start) begin
          state_nxt_s = ST_IDLE;
          pc_nxt_s    = START_PC;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pc_nxt_s    = START_PC;
      end
    endcase
  end

  // State, PC, count and status-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= START_PC;
      cnt_r    <= 16'd0;
      in_run_r <= 1'b0;
      done_r   <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      cnt_r    <= cnt_nxt_s;
      in_run_r <= (state_nxt_s == ST_RUN);
      done_r   <= (state_nxt_s == ST_DONE);
      fault_r  <= (state_nxt_s == ST_FAULT);
    end
  end

  // run must drop in the same cycle a stall arrives, so only the RUN-state
  // part is registered and stall gates it directly.
  assign run         = in_run_r & ~stall;
  assign pc_out      = pc_r;
  assign done        = done_r;
  assign fault       = fault_r;
  assign instr_count = cnt_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural program model,
// a per-cycle compare process and directed scenarios with literal checks.
module tb_fetch_sequencer;

  localparam logic [15:0] START = 16'd0;
  localparam logic [15:0] PLEN  = 16'd132;
  localparam logic [15:0] NONE  = 16'hFFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        format;
  logic [3:0]  opcode;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        stall;
  logic [15:0] pc_out;
  logic        run;
  logic        done;
  logic        fault;
  logic [15:0] instr_count;

  // Program description: one halt address, one branch site.
  logic [15:0] halt_addr;
  logic [15:0] br_addr;
  logic [15:0] br_tgt;

  int n_cmp;
  int n_bad;
  int run_total;

  fetch_sequencer #(.START_PC(START), .PROG_LEN(PLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .format(format), .opcode(opcode),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .pc_out(pc_out), .run(run), .done(done), .fault(fault), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM + datapath; non-halt words are near-miss encodings.
  always_comb begin
    if (pc_out == halt_addr) begin
      format = 1'b1; opcode = 4'b1011;
    end else if (pc_out[0]) begin
      format = 1'b0; opcode = 4'b1011;
    end else begin
      format = 1'b1; opcode = 4'b1010;
    end
    branch_taken  = (pc_out == br_addr);
    branch_target = br_tgt;
  end

  // Behavioural model: a program runner with flags, not a state machine copy.
  logic        m_running, m_done, m_fault;
  logic [15:0] m_pc;
  int          m_count;
  initial begin
    m_running = 1'b0; m_done = 1'b0; m_fault = 1'b0; m_pc = START; m_count = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running = 1'b0; m_done = 1'b0; m_fault = 1'b0; m_pc = START; m_count = 0;
    end else if (m_running) begin
      if (!stall) begin
        if (m_count < 65535) m_count = m_count + 1;
        if (m_pc == halt_addr) begin
          m_running = 1'b0;
          m_done    = 1'b1;
        end else begin
          m_pc = (m_pc == br_addr) ? br_tgt : m_pc + 16'd1;
          if (m_pc >= PLEN) begin
            m_running = 1'b0;
            m_fault   = 1'b1;
          end
        end
      end
    end else if (m_done || m_fault) begin
      if (!start) begin
        m_done = 1'b0; m_fault = 1'b0; m_pc = START;
      end
    end else if (start) begin
      m_running = 1'b1; m_pc = START; m_count = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("pc_out", {16'd0, pc_out}, {16'd0, m_pc});
    check("run", {31'd0, run}, {31'd0, m_running & ~stall});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("fault", {31'd0, fault}, {31'd0, m_fault});
    check("instr_count", {16'd0, instr_count}, m_count);
    if (run) run_total++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pc(input logic [15:0] v);
    int k;
    for (k = 0; k < 400; k++) begin
      if (pc_out == v) break;
      step();
    end
    check("wait_pc_timeout", {16'd0, pc_out}, {16'd0, v});
  endtask

  // which: 0 = done, 1 = fault
  task automatic wait_flag(input int which);
    int k;
    logic f;
    f = 1'b0;
    for (k = 0; k < 400; k++) begin
      f = (which == 0) ? done : fault;
      if (f) break;
      step();
    end
    check(which == 0 ? "wait_done_timeout" : "wait_fault_timeout", {31'd0, f}, 32'd1);
  endtask

  task automatic finish_run();
    start = 1'b0;
    step(); step();
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_fault", {31'd0, fault}, 32'd0);
    check("idle_pc", {16'd0, pc_out}, {16'd0, START});
  endtask

  initial begin
    int r0;
    n_cmp = 0; n_bad = 0; run_total = 0;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    halt_addr = NONE; br_addr = NONE; br_tgt = 16'd0;
    #22;
    check("reset_pc", {16'd0, pc_out}, {16'd0, START});
    check("reset_cnt", {16'd0, instr_count}, 32'd0);
    rst_n = 1'b1;
    step();

    // Linear run, halt at 5.
    halt_addr = 16'd5; r0 = run_total;
    start = 1'b1;
    wait_flag(0);
    check("lin_pc", {16'd0, pc_out}, 32'd5);
    check("lin_cnt", {16'd0, instr_count}, 32'd6);
    check("lin_run_cycles", run_total - r0, 32'd6);
    step();
    check("lin_done_held", {31'd0, done}, 32'd1);
    check("lin_run_low", {31'd0, run}, 32'd0);
    finish_run();

    // Branch at 3 to 40, halt at 42.
    halt_addr = 16'd42; br_addr = 16'd3; br_tgt = 16'd40;
    start = 1'b1;
    wait_pc(16'd3);
    step();
    check("br_target", {16'd0, pc_out}, 32'd40);
    step();
    check("br_next", {16'd0, pc_out}, 32'd41);
    wait_flag(0);
    check("br_cnt", {16'd0, instr_count}, 32'd7);
    finish_run();

    // Stall 3 cycles at 7, halt at 9; start drop mid-run is ignored.
    halt_addr = 16'd9; br_addr = NONE;
    start = 1'b1;
    wait_pc(16'd2);
    start = 1'b0;
    wait_pc(16'd7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", {16'd0, pc_out}, 32'd7);
      check("stall_cnt", {16'd0, instr_count}, 32'd7);
    end
    stall = 1'b0;
    step();
    check("stall_resume", {16'd0, pc_out}, 32'd8);
    wait_flag(0);
    check("stall_total", {16'd0, instr_count}, 32'd10);
    finish_run();

    // Halt + branch + stall together at 10.
    halt_addr = 16'd10; br_addr = 16'd10; br_tgt = 16'd30;
    start = 1'b1;
    wait_pc(16'd10);
    stall = 1'b1;
    step(); step();
    check("hb_no_done_in_stall", {31'd0, done}, 32'd0);
    stall = 1'b0;
    step();
    check("hb_done", {31'd0, done}, 32'd1);
    check("hb_pc", {16'd0, pc_out}, 32'd10);
    check("hb_cnt", {16'd0, instr_count}, 32'd11);
    finish_run();

    // Runaway: no halt, faults on reaching PROG_LEN.
    halt_addr = NONE; br_addr = NONE;
    start = 1'b1;
    wait_flag(1);
    check("run_pc", {16'd0, pc_out}, 32'd132);
    check("run_done", {31'd0, done}, 32'd0);
    check("run_cnt", {16'd0, instr_count}, 32'd132);
    start = 1'b0;
    step(); step();
    check("run_idle_fault", {31'd0, fault}, 32'd0);
    check("run_cnt_kept", {16'd0, instr_count}, 32'd132);
    start = 1'b1;
    step();
    check("rerun_pc", {16'd0, pc_out}, 32'd0);
    check("rerun_cnt", {16'd0, instr_count}, 32'd0);
    start = 1'b0;
    wait_pc(16'd6);
    halt_addr = 16'd6;
    wait_flag(0);
    finish_run();

    // Branch target beyond PROG_LEN.
    halt_addr = NONE; br_addr = 16'd2; br_tgt = 16'd200;
    start = 1'b1;
    wait_flag(1);
    check("brf_pc", {16'd0, pc_out}, 32'd200);
    check("brf_cnt", {16'd0, instr_count}, 32'd3);
    finish_run();

    // Reset mid-run at PC 20.
    br_addr = NONE;
    start = 1'b1;
    wait_pc(16'd20);
    check("pre_rst_cnt", {16'd0, instr_count}, 32'd20);
    rst_n = 1'b0;
    #1;
    check("arst_pc", {16'd0, pc_out}, 32'd0);
    check("arst_cnt", {16'd0, instr_count}, 32'd0);
    check("arst_run", {31'd0, run}, 32'd0);
    check("arst_done", {31'd0, done | fault}, 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_run", {31'd0, run}, 32'd1);
    check("post_rst_pc", {16'd0, pc_out}, 32'd0);
    step();
    check("post_rst_pc1", {16'd0, pc_out}, 32'd1);
    halt_addr = 16'd3;
    wait_flag(0);
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
